// File: rtl/pixel_array_ctrl_if.sv
// Control/status bundle between the camera sequencer and its host.
// master drives the requests, slave is the sequencer itself.
interface pixel_array_ctrl_if #(
    parameter int ROWS  = 2,
    parameter int EXP_W = 5
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic             init;
    logic             mode;
    logic             abort;
    logic             exp_inc;
    logic             exp_dec;
    logic [ROWS-1:0]  nre;
    logic             adc;
    logic             expose;
    logic             erase;
    logic             busy;
    logic             frame_done;
    logic [EXP_W-1:0] ex_time;
    logic [RW-1:0]    row_idx;

    modport master (
        output init, mode, abort, exp_inc, exp_dec,
        input  nre, adc, expose, erase, busy,
        input  frame_done, ex_time, row_idx
    );

    modport slave (
        input  init, mode, abort, exp_inc, exp_dec,
        output nre, adc, expose, erase, busy,
        output frame_done, ex_time, row_idx
    );
endinterface

// File: rtl/pixel_array_ctrl.sv
// Exposure/readout sequencer for an N-row pixel array.
// Every output is a flop loaded from the next-state view of the FSM.
module pixel_array_ctrl #(
    parameter int ROWS    = 2,
    parameter int EXP_W   = 5,
    parameter int EXP_MIN = 2,
    parameter int EXP_MAX = 30,
    parameter int EXP_DEF = 5,
    parameter int ROW_CYC = 4,
    parameter int ADC_POS = 1
) (
    input  logic              clk,
    input  logic              reset,
    pixel_array_ctrl_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW = $clog2(ROW_CYC);

    localparam logic [KW-1:0]    K_LAST = KW'(ROW_CYC - 1);
    localparam logic [KW-1:0]    K_ADC  = KW'(ADC_POS);
    localparam logic [RW-1:0]    R_LAST = RW'(ROWS - 1);
    localparam logic [EXP_W-1:0] E_MIN  = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] E_MAX  = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] E_DEF  = EXP_W'(EXP_DEF);
    localparam logic [EXP_W-1:0] E_ONE  = EXP_W'(1);

    typedef enum logic [1:0] {IDLE, EXPOSE, READOUT} state_t;

    state_t           state_q, state_d;
    logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
    logic [EXP_W-1:0] ex_time_q, ex_time_d;
    logic [KW-1:0]    k_q, k_d;
    logic [RW-1:0]    row_q, row_d;
    logic             restart_q, restart_d;
    logic             done;

    logic [ROWS-1:0]  nre_q, nre_d;
    logic             adc_q, adc_d;
    logic             expose_q, expose_d;
    logic             erase_q, erase_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            exp_cnt_q    <= '0;
            ex_time_q    <= E_DEF;
            k_q          <= '0;
            row_q        <= '0;
            restart_q    <= 1'b0;
            nre_q        <= '1;
            adc_q        <= 1'b0;
            expose_q     <= 1'b0;
            erase_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_cnt_q    <= exp_cnt_d;
            ex_time_q    <= ex_time_d;
            k_q          <= k_d;
            row_q        <= row_d;
            restart_q    <= restart_d;
            nre_q        <= nre_d;
            adc_q        <= adc_d;
            expose_q     <= expose_d;
            erase_q      <= erase_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        ex_time_d = ex_time_q;
        k_d       = k_q;
        row_d     = row_q;
        restart_d = restart_q;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.exp_inc)
                    ex_time_d = (ex_time_q >= E_MAX) ? E_MAX : ex_time_q + 1'b1;
                else if (bus.exp_dec)
                    ex_time_d = (ex_time_q <= E_MIN) ? E_MIN : ex_time_q - 1'b1;
                // abort in IDLE only serves to veto a start
                if (!bus.abort && (bus.init || (bus.mode && restart_q))) begin
                    state_d   = EXPOSE;
                    exp_cnt_d = ex_time_q;
                    restart_d = 1'b0;
                end
            end
            EXPOSE: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    exp_cnt_d = '0;
                    restart_d = 1'b0;
                end else if (exp_cnt_q <= E_ONE) begin
                    state_d   = READOUT;
                    exp_cnt_d = '0;
                    k_d       = '0;
                    row_d     = '0;
                end else begin
                    exp_cnt_d = exp_cnt_q - 1'b1;
                end
            end
            READOUT: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    k_d       = '0;
                    row_d     = '0;
                    restart_d = 1'b0;
                end else if (k_q == K_LAST) begin
                    k_d = '0;
                    if (row_q == R_LAST) begin
                        state_d   = IDLE;
                        row_d     = '0;
                        done      = 1'b1;
                        restart_d = bus.mode;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nre_d = '1;
        for (int i = 0; i < ROWS; i++) begin
            if (state_d == READOUT && k_d != K_LAST && row_d == RW'(i))
                nre_d[i] = 1'b0;
        end
        adc_d        = (state_d == READOUT) && (k_d == K_ADC);
        expose_d     = (state_d == EXPOSE);
        erase_d      = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        frame_done_d = done;
    end

    assign bus.nre        = nre_q;
    assign bus.adc        = adc_q;
    assign bus.expose     = expose_q;
    assign bus.erase      = erase_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.ex_time    = ex_time_q;
    assign bus.row_idx    = row_q;
endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: default 2-row build
// plus a 4-row / 5-cycle-slot build.
module tb_pixel_array_ctrl;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    pixel_array_ctrl_if #(.ROWS(2), .EXP_W(5)) bus1 ();
    pixel_array_ctrl_if #(.ROWS(4), .EXP_W(5)) bus2 ();

    pixel_array_ctrl dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    pixel_array_ctrl #(
        .ROWS    (4),
        .ROW_CYC (5),
        .ADC_POS (3)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {expose, erase, busy, adc, frame_done, nre[1:0], row_idx}
    localparam logic [7:0] SINGLE [15] = '{
        8'b1010_0110, 8'b1010_0110, 8'b1010_0110,
        8'b1010_0110, 8'b1010_0110,
        8'b0010_0100, 8'b0011_0100, 8'b0010_0100, 8'b0010_0110,
        8'b0010_0011, 8'b0011_0011, 8'b0010_0011, 8'b0010_0111,
        8'b0100_1110, 8'b0100_0110
    };

    task automatic wait_fd(output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus1.frame_done) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [11:0] o;
        logic [11:0] e;
        e = {5'd5, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
        reset = 1'b1;
        @(negedge clk);
        o = {bus1.ex_time, bus1.erase, bus1.expose, bus1.nre,
             bus1.busy, bus1.adc, bus1.frame_done, bus1.row_idx};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL reset_held got %h want %h", o, e);
        end
        reset = 1'b0;
        @(negedge clk);
        o = {bus1.ex_time, bus1.erase, bus1.expose, bus1.nre,
             bus1.busy, bus1.adc, bus1.frame_done, bus1.row_idx};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL reset_released got %h want %h", o, e);
        end
        n_cmp++;
        if ({bus2.ex_time, bus2.nre, bus2.row_idx, bus2.erase}
            !== {5'd5, 4'hF, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_wide got %h/%h/%h want 5/f/0",
                     bus2.ex_time, bus2.nre, bus2.row_idx);
        end
    endtask

    task automatic test_single();
        logic [7:0] o;
        @(negedge clk);
        bus1.init = 1'b1;
        @(negedge clk);
        bus1.init = 1'b0;
        for (int i = 0; i < 15; i++) begin
            o = {bus1.expose, bus1.erase, bus1.busy, bus1.adc,
                 bus1.frame_done, bus1.nre, bus1.row_idx};
            n_cmp++;
            if (o !== SINGLE[i]) begin
                n_bad++;
                $display("FAIL single_cyc%0d got %b want %b",
                         i, o, SINGLE[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_continuous();
        bit hit;
        bus1.mode = 1'b1;
        bus1.init = 1'b1;
        @(negedge clk);
        bus1.init = 1'b0;
        for (int f = 1; f <= 2; f++) begin
            wait_fd(hit);
            n_cmp++;
            if (!hit || bus1.erase !== 1'b1) begin
                n_bad++;
                $display("FAIL cont_frame%0d got hit=%0b erase=%b want 1/1",
                         f, hit, bus1.erase);
            end
            @(negedge clk);
            n_cmp++;
            if ({bus1.expose, bus1.erase} !== 2'b10) begin
                n_bad++;
                $display("FAIL cont_gap%0d got %b want 10",
                         f, {bus1.expose, bus1.erase});
            end
        end
        repeat (2) @(negedge clk);
        bus1.mode = 1'b0;
        wait_fd(hit);
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL cont_frame3 got timeout want frame_done");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus1.busy, bus1.erase} !== 2'b01) begin
                n_bad++;
                $display("FAIL cont_stop%0d got %b want 01",
                         i, {bus1.busy, bus1.erase});
            end
        end
    endtask

    task automatic test_saturation();
        bit hit;
        bus1.exp_inc = 1'b1;
        repeat (30) @(negedge clk);
        bus1.exp_inc = 1'b0;
        n_cmp++;
        if (bus1.ex_time !== 5'd30) begin
            n_bad++;
            $display("FAIL sat_max got %0d want 30", bus1.ex_time);
        end
        bus1.exp_dec = 1'b1;
        repeat (40) @(negedge clk);
        bus1.exp_dec = 1'b0;
        n_cmp++;
        if (bus1.ex_time !== 5'd2) begin
            n_bad++;
            $display("FAIL sat_min got %0d want 2", bus1.ex_time);
        end
        bus1.exp_inc = 1'b1;
        repeat (8) @(negedge clk);
        bus1.exp_inc = 1'b0;
        n_cmp++;
        if (bus1.ex_time !== 5'd10) begin
            n_bad++;
            $display("FAIL sat_to10 got %0d want 10", bus1.ex_time);
        end
        bus1.exp_inc = 1'b1;
        bus1.exp_dec = 1'b1;
        @(negedge clk);
        bus1.exp_inc = 1'b0;
        bus1.exp_dec = 1'b0;
        n_cmp++;
        if (bus1.ex_time !== 5'd11) begin
            n_bad++;
            $display("FAIL sat_both got %0d want 11", bus1.ex_time);
        end
        bus1.init = 1'b1;
        @(negedge clk);
        bus1.init = 1'b0;
        bus1.exp_inc = 1'b1;
        repeat (3) @(negedge clk);
        bus1.exp_inc = 1'b0;
        n_cmp++;
        if ({bus1.expose, bus1.ex_time} !== {1'b1, 5'd11}) begin
            n_bad++;
            $display("FAIL sat_busy got exp=%b t=%0d want 1/11",
                     bus1.expose, bus1.ex_time);
        end
        wait_fd(hit);
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL sat_frame got timeout want frame_done");
        end
    endtask

    task automatic test_abort_readout();
        bit hit;
        bus1.mode = 1'b1;
        bus1.init = 1'b1;
        @(negedge clk);
        bus1.init = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus1.busy && bus1.row_idx == 1'b1) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL abort_rd_reach got timeout want row 1");
        end
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        n_cmp++;
        if ({bus1.nre, bus1.adc, bus1.erase, bus1.busy, bus1.frame_done}
            !== 6'b11_0100) begin
            n_bad++;
            $display("FAIL abort_rd got %b want 110100",
                     {bus1.nre, bus1.adc, bus1.erase,
                      bus1.busy, bus1.frame_done});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus1.busy, bus1.frame_done} !== 2'b00) begin
                n_bad++;
                $display("FAIL abort_norestart%0d got %b want 00",
                         i, {bus1.busy, bus1.frame_done});
            end
        end
        bus1.mode = 1'b0;
    endtask

    task automatic test_abort_expose();
        bus1.init = 1'b1;
        @(negedge clk);
        bus1.init = 1'b0;
        n_cmp++;
        if (bus1.expose !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_exp_pre got %b want 1", bus1.expose);
        end
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        n_cmp++;
        if ({bus1.expose, bus1.erase, bus1.frame_done} !== 3'b010) begin
            n_bad++;
            $display("FAIL abort_exp got %b want 010",
                     {bus1.expose, bus1.erase, bus1.frame_done});
        end
    endtask

    task automatic test_reset_mid();
        bus1.exp_inc = 1'b1;
        repeat (9) @(negedge clk);
        bus1.exp_inc = 1'b0;
        n_cmp++;
        if (bus1.ex_time !== 5'd20) begin
            n_bad++;
            $display("FAIL rst_mid_set got %0d want 20", bus1.ex_time);
        end
        bus1.init = 1'b1;
        @(negedge clk);
        bus1.init = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus1.expose !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre got %b want 1", bus1.expose);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus1.expose, bus1.erase, bus1.busy, bus1.nre, bus1.ex_time}
            !== {3'b010, 2'b11, 5'd5}) begin
            n_bad++;
            $display("FAIL rst_mid got %b want 0101100101",
                     {bus1.expose, bus1.erase, bus1.busy,
                      bus1.nre, bus1.ex_time});
        end
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus1.busy, bus1.erase, bus1.ex_time} !== {2'b01, 5'd5}) begin
            n_bad++;
            $display("FAIL rst_mid_after got %b want 0100101",
                     {bus1.busy, bus1.erase, bus1.ex_time});
        end
    endtask

    task automatic test_wide();
        logic [6:0] o;
        logic [6:0] e;
        logic [3:0] one;
        one = 4'b0001;
        @(negedge clk);
        bus2.init = 1'b1;
        @(negedge clk);
        bus2.init = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({bus2.expose, bus2.busy, bus2.nre} !== 6'b11_1111) begin
                n_bad++;
                $display("FAIL wide_exp%0d got %b want 111111",
                         c, {bus2.expose, bus2.busy, bus2.nre});
            end
            @(negedge clk);
        end
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) begin
                e = {(k < 4) ? ~(one << r) : 4'hF, k == 3, 2'(r)};
                o = {bus2.nre, bus2.adc, bus2.row_idx};
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL wide_r%0d_k%0d got %b want %b",
                             r, k, o, e);
                end
                @(negedge clk);
            end
        end
        n_cmp++;
        if ({bus2.frame_done, bus2.erase, bus2.busy, bus2.nre}
            !== 7'b110_1111) begin
            n_bad++;
            $display("FAIL wide_done got %b want 1101111",
                     {bus2.frame_done, bus2.erase, bus2.busy, bus2.nre});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus1.init = 1'b0;
        bus1.mode = 1'b0;
        bus1.abort = 1'b0;
        bus1.exp_inc = 1'b0;
        bus1.exp_dec = 1'b0;
        bus2.init = 1'b0;
        bus2.mode = 1'b0;
        bus2.abort = 1'b0;
        bus2.exp_inc = 1'b0;
        bus2.exp_dec = 1'b0;
        test_reset();
        test_single();
        test_continuous();
        test_saturation();
        test_abort_readout();
        test_abort_expose();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
Parametrised exposure/readout sequencer for an N-row pixel array in the digi_cam datapath. It drives the global erase and expose lines, the per-row active-low read enables and the ADC conversion strobe. It also holds a user-adjustable exposure time. Compared with the 2-row controller it adds a generic row count and slot timing, continuous-capture mode, abort, and busy/frame_done status.

Parameters:
ROWS, 2, number of pixel rows read per frame (>=1)
EXP_W, 5, width of exposure-time register
EXP_MIN, 2, minimum exposure time in clk cycles (>=1)
EXP_MAX, 30, maximum exposure time in clk cycles (<2^EXP_W)
EXP_DEF, 5, exposure time after reset (EXP_MIN..EXP_MAX)
ROW_CYC, 4, clk cycles per row readout slot (>=3)
ADC_POS, 1, slot cycle index at which adc pulses (0..ROW_CYC-2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
init  in  1  frame start request, level-sampled in IDLE
mode  in  1  0 = single-shot, 1 = continuous capture
abort  in  1  terminate current frame
exp_inc  in  1  increment exposure time (IDLE only)
exp_dec  in  1  decrement exposure time (IDLE only)
nre  out  ROWS  per-row read enable, active low
adc  out  1  ADC conversion strobe, 1-cycle pulse
expose  out  1  pixel exposure enable
erase  out  1  pixel reset/erase
busy  out  1  high in EXPOSE and READOUT
frame_done  out  1  1-cycle pulse on normal frame completion
ex_time  out  EXP_W  current exposure time
row_idx  out  max(1,clog2(ROWS))  row currently being read

Behaviour:
- Reset is clk and reset as decided above: reset asynchronous, active-high; clock clk.
- Reset values: state IDLE, erase=1, expose=0, nre=all 1, adc=0, busy=0, frame_done=0, ex_time=EXP_DEF, row_idx=0, all counters 0, restart flag 0.
- All outputs are registered. They change only on posedge clk, or on reset.
- FSM has three states: IDLE, EXPOSE, READOUT.
- IDLE:
  - Outputs: erase=1, expose=0, nre all 1, adc=0, busy=0.
  - Start condition: init=1, or (mode=1 and restart flag=1). When it holds, the next cycle is EXPOSE.
  - ex_time is latched into the exposure counter on the EXPOSE entry edge.
- ex_time adjust is evaluated only while in IDLE, once per cycle:
  - exp_inc=1: ex_time+1, saturating at EXP_MAX. exp_inc has priority when both inputs are high.
  - exp_dec=1 with exp_inc=0: ex_time-1, saturating at EXP_MIN.
  - Otherwise ex_time holds.
  - Any adjustment in EXPOSE or READOUT is ignored.
- EXPOSE:
  - Outputs: expose=1, erase=0, busy=1.
  - Lasts exactly the latched ex_time cycles, then goes to READOUT.
- READOUT:
  - Lasts ROWS*ROW_CYC cycles. Rows are read in order r=0..ROWS-1; slot cycle k=0..ROW_CYC-1.
  - nre[r]=0 for k<=ROW_CYC-2. At k=ROW_CYC-1 all nre=1 (gap cycle).
  - adc=1 only at k=ADC_POS. row_idx=r.
  - After the last gap cycle: next state IDLE, frame_done=1 for that single cycle, restart flag set to mode.
- The restart flag clears when the FSM leaves IDLE. In continuous mode, consecutive frames are therefore separated by exactly one IDLE/erase cycle.
- Clearing mode mid-frame: the current frame completes, then the FSM stays in IDLE.
- init while busy is ignored. Holding init high in IDLE restarts a frame after a 1-cycle IDLE.
- abort=1 in EXPOSE or READOUT:
  - The next cycle is IDLE with IDLE outputs. frame_done stays 0 and the restart flag is cleared.
  - abort has priority over normal state completion in the same cycle.
  - abort in IDLE has no effect, and blocks the start condition in that cycle.
- reset asserted mid-frame returns everything to reset values immediately. ex_time reverts to EXP_DEF.
- At most one nre bit is low at any time. adc is never high while all nre are high.

Test Plan:
- Defaults, reset released -> ex_time=5, erase=1, expose=0, nre=2'b11, busy=0.
- Single-shot, init pulsed 1 cycle -> expose high exactly 5 cycles, then:
  - nre=2'b10 for 3 cycles, adc on the 2nd, 1 gap cycle;
  - nre=2'b01 for 3 cycles, adc on the 2nd, 1 gap cycle;
  - then IDLE with frame_done=1 for one cycle, erase=1. Total busy = 13 cycles.
- Saturation in IDLE:
  - 30 exp_inc cycles -> ex_time=30;
  - 40 exp_dec cycles -> ex_time=2;
  - exp_inc and exp_dec together from 10 -> 11;
  - exp_inc during EXPOSE -> unchanged.
- Continuous, mode=1 with a single init pulse -> back-to-back frames with exactly one erase cycle between them. Drop mode during frame 3 -> frame 3 completes with frame_done, then the FSM stays in IDLE.
- Abort:
  - abort during READOUT row 1 -> next cycle all nre=1, adc=0, erase=1, no frame_done, no restart even with mode=1;
  - abort during EXPOSE -> expose drops next cycle.
- reset asserted mid-EXPOSE with ex_time=20 -> immediate IDLE outputs and ex_time=5. ROWS=4, ROW_CYC=5, ADC_POS=3 build -> 4 row slots of 5 cycles, adc at k=3, row_idx 0..3.
